// File: rtl/bcd_interval_timer.sv
// BCD interval timer: sexagesimal digit pairs counting down (alarm) or up (stopwatch),
// with load clamping, pause/resume, expiry detection and a flashing alarm output.
module bcd_interval_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int FLASH_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start_stop,
  input  logic                    count_up,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    flash
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  // Tens digits of each pair stop at 5; the top digit is always allowed to reach 9.
  function automatic logic [3:0] digit_max(input int idx);
    if (idx == NUM_DIGITS - 1) begin
      return 4'd9;
    end else if ((idx % 2) == 1) begin
      return 4'd5;
    end else begin
      return 4'd9;
    end
  endfunction

  function automatic logic [DW-1:0] max_value();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v[4*i +: 4] = digit_max(i);
    end
    return v;
  endfunction

  localparam logic [DW-1:0] MAXVAL = max_value();

  state_t        state_q, state_d;
  logic [DW-1:0] digits_q, digits_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_q, flash_d;
  logic          mode_q, mode_d;

  logic [DW-1:0] clamped;
  logic [DW-1:0] dec_val;
  logic [DW-1:0] inc_val;
  logic          borrow;
  logic          carry;

  // Load clamping plus ripple BCD decrement/increment, all per digit.
  always_comb begin
    clamped = load_value;
    dec_val = digits_q;
    inc_val = digits_q;
    borrow  = 1'b1;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > digit_max(i)) begin
        clamped[4*i +: 4] = digit_max(i);
      end
      if (borrow) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = digit_max(i);
        end else begin
          dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (carry) begin
        if (digits_q[4*i +: 4] >= digit_max(i)) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    tick_d      = tick_q;
    mode_d      = mode_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;

    if (clear) begin
      state_d  = IDLE;
      digits_d = '0;
      tick_d   = '0;
    end else if (load && (state_q != RUN)) begin
      state_d  = IDLE;
      digits_d = clamped;
      tick_d   = '0;
    end else if (start_stop) begin
      case (state_q)
        IDLE: begin
          if (count_up ? (digits_q != MAXVAL) : (digits_q != '0)) begin
            mode_d  = count_up;
            state_d = RUN;
            tick_d  = '0;
          end
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        EXPIRED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q == RUN) begin
      // A pause edge takes priority over a step, so the held tick value resumes intact.
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (mode_q) begin
          digits_d = inc_val;
          if (inc_val == MAXVAL) begin
            state_d = EXPIRED;
          end
        end else begin
          digits_d = dec_val;
          if (dec_val == '0) begin
            state_d = EXPIRED;
          end
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if ((state_d == EXPIRED) && (state_q != EXPIRED)) begin
      flash_d     = 1'b1;
      flash_cnt_d = '0;
    end else if (state_d == EXPIRED) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_d     = ~flash_q;
        flash_cnt_d = '0;
      end else begin
        flash_cnt_d = flash_cnt_q + FW'(1);
      end
    end else begin
      flash_d     = 1'b0;
      flash_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      tick_q      <= '0;
      mode_q      <= 1'b0;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      tick_q      <= tick_d;
      mode_q      <= mode_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign flash   = flash_q;

endmodule

// File: tb/tb_bcd_interval_timer.sv
// Directed bench for bcd_interval_timer with NUM_DIGITS=4, TICK_DIV=4, FLASH_DIV=3.
module tb_bcd_interval_timer;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        start_stop;
  logic        count_up;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        flash;

  int checks;
  int errors;

  bcd_interval_timer #(
    .NUM_DIGITS(4),
    .TICK_DIV  (4),
    .FLASH_DIV (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .start_stop(start_stop),
    .count_up  (count_up),
    .digits    (digits),
    .running   (running),
    .expired   (expired),
    .flash     (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_value = v;
    load       = 1'b1;
    step(1);
    load       = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({digits, running, expired, flash} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got digits=%h run=%b exp=%b flash=%b, expected all 0",
               digits, running, expired, flash);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_down_borrow();
    count_up = 1'b0;
    pulse_load(16'h0102);
    pulse_start();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_running_on_start: got %b expected 1", running);
    end
    step(3);
    checks++;
    if (digits !== 16'h0102) begin
      errors++;
      $display("[TB] FAIL down_no_early_step: got %h expected 0102", digits);
    end
    step(1);
    checks++;
    if (digits !== 16'h0101) begin
      errors++;
      $display("[TB] FAIL down_step1: got %h expected 0101", digits);
    end
    step(4);
    checks++;
    if (digits !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL down_step2: got %h expected 0100", digits);
    end
    step(4);
    checks++;
    if ((digits !== 16'h0059) || (running !== 1'b1)) begin
      errors++;
      $display("[TB] FAIL down_borrow: got %h run=%b expected 0059 run=1", digits, running);
    end
    pulse_clear();
  endtask

  task automatic test_expire_flash();
    logic exp_flash [0:6];
    exp_flash = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    count_up = 1'b0;
    pulse_load(16'h0001);
    pulse_start();
    step(4);
    checks++;
    if ((digits !== 16'h0000) || (expired !== 1'b1) || (running !== 1'b0)) begin
      errors++;
      $display("[TB] FAIL down_expire: got %h exp=%b run=%b expected 0000 exp=1 run=0",
               digits, expired, running);
    end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1);
      checks++;
      if (flash !== exp_flash[i]) begin
        errors++;
        $display("[TB] FAIL flash_seq[%0d]: got %b expected %b", i, flash, exp_flash[i]);
      end
    end
    pulse_start();
    checks++;
    if ((flash !== 1'b0) || (expired !== 1'b0) || (running !== 1'b0) || (digits !== 16'h0000)) begin
      errors++;
      $display("[TB] FAIL expire_ack: got flash=%b exp=%b run=%b digits=%h expected 0 0 0 0000",
               flash, expired, running, digits);
    end
  endtask

  task automatic test_up_saturate();
    count_up = 1'b1;
    pulse_load(16'h0059);
    pulse_start();
    step(4);
    checks++;
    if (digits !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL up_carry: got %h expected 0100", digits);
    end
    pulse_clear();
    pulse_load(16'h9958);
    pulse_start();
    step(4);
    checks++;
    if ((digits !== 16'h9959) || (expired !== 1'b1)) begin
      errors++;
      $display("[TB] FAIL up_expire: got %h exp=%b expected 9959 exp=1", digits, expired);
    end
    step(6);
    checks++;
    if (digits !== 16'h9959) begin
      errors++;
      $display("[TB] FAIL up_saturate: got %h expected 9959", digits);
    end
    pulse_start();
    checks++;
    if ((expired !== 1'b0) || (running !== 1'b0) || (digits !== 16'h9959)) begin
      errors++;
      $display("[TB] FAIL up_ack: got exp=%b run=%b digits=%h expected 0 0 9959",
               expired, running, digits);
    end
    pulse_start();
    step(1);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_start_at_max: got run=%b expected 0", running);
    end
    count_up = 1'b0;
    pulse_clear();
  endtask

  task automatic test_pause_resume();
    count_up = 1'b0;
    pulse_load(16'h0010);
    pulse_start();
    step(2);
    pulse_start();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_enter: got run=%b expected 0", running);
    end
    count_up = 1'b1;
    step(10);
    checks++;
    if (digits !== 16'h0010) begin
      errors++;
      $display("[TB] FAIL pause_hold: got %h expected 0010", digits);
    end
    pulse_start();
    checks++;
    if ((running !== 1'b1) || (digits !== 16'h0010)) begin
      errors++;
      $display("[TB] FAIL resume: got run=%b digits=%h expected 1 0010", running, digits);
    end
    step(1);
    checks++;
    if (digits !== 16'h0010) begin
      errors++;
      $display("[TB] FAIL resume_no_early_step: got %h expected 0010", digits);
    end
    step(1);
    checks++;
    if (digits !== 16'h0009) begin
      errors++;
      $display("[TB] FAIL resume_step: got %h expected 0009", digits);
    end
    step(4);
    checks++;
    if (digits !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL mode_latched: got %h expected 0008", digits);
    end
    count_up = 1'b0;
    pulse_clear();
  endtask

  task automatic test_load_priority();
    count_up = 1'b0;
    pulse_load(16'hFF7C);
    checks++;
    if (digits !== 16'h9959) begin
      errors++;
      $display("[TB] FAIL load_clamp: got %h expected 9959", digits);
    end
    pulse_start();
    pulse_load(16'h1234);
    checks++;
    if ((digits !== 16'h9959) || (running !== 1'b1)) begin
      errors++;
      $display("[TB] FAIL load_in_run: got %h run=%b expected 9959 run=1", digits, running);
    end
    clear      = 1'b1;
    load       = 1'b1;
    load_value = 16'h0042;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    load       = 1'b0;
    start_stop = 1'b0;
    checks++;
    if ((digits !== 16'h0000) || (running !== 1'b0) || (expired !== 1'b0)) begin
      errors++;
      $display("[TB] FAIL clear_priority: got %h run=%b exp=%b expected 0000 0 0",
               digits, running, expired);
    end
  endtask

  task automatic test_reset_mid_run();
    count_up = 1'b0;
    pulse_load(16'h0005);
    pulse_start();
    step(3);
    reset = 1'b1;
    #1;
    checks++;
    if ({digits, running, expired, flash} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: got digits=%h run=%b exp=%b flash=%b expected all 0",
               digits, running, expired, flash);
    end
    step(2);
    #2;
    reset = 1'b0;
    step(1);
    pulse_start();
    step(4);
    checks++;
    if ((running !== 1'b0) || (digits !== 16'h0000)) begin
      errors++;
      $display("[TB] FAIL start_at_zero: got run=%b digits=%h expected 0 0000", running, digits);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    start_stop = 1'b0;
    count_up   = 1'b0;
    test_reset();
    test_down_borrow();
    test_expire_flash();
    test_up_saturate();
    test_pause_resume();
    test_load_priority();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_interval_timer.md
Name: bcd_interval_timer

Overview:
- Parametrised successor to the fixed four-digit egg-timer datapath. Merges the time-register, decrement and flash-enable functions into one block.
- Holds NUM_DIGITS BCD digits arranged as sexagesimal pairs (ss, mm, hh…). Counts down (alarm timer) or up (stopwatch) at one step per TICK_DIV clocks.
- Raises an expiry flag and a flashing alarm output.
- Sits between the debounced KEY/SW logic and the seven-segment decoders / LEDR driver in the top level.

Parameters:
- NUM_DIGITS, 4, number of BCD digits. Even, 2..8.
- TICK_DIV, 50000000, clk cycles per count step. Must be ≥ 2.
- FLASH_DIV, 25000000, clk cycles per alarm flash half-period. Must be ≥ 1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  single-cycle pulse: abort and zero the count.
- load  in  1  single-cycle pulse: load load_value.
- load_value  in  4*NUM_DIGITS  BCD preset; digit 0 is the LSB nibble.
- start_stop  in  1  single-cycle pulse: start / pause / resume / acknowledge.
- count_up  in  1  mode select, 1 = stopwatch, 0 = countdown.
- digits  out  4*NUM_DIGITS  current BCD count.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.
- flash  out  1  alarm blink, 0 outside EXPIRED.

Behaviour:
- Reset (async): state = IDLE, digits = 0, tick_cnt = 0, flash_cnt = 0, mode latch = 0. Outputs running = 0, expired = 0, flash = 0.
- Digit limits:
  - Odd-index digits (tens of seconds, tens of minutes, …): max 5.
  - Even-index digits: max 9.
  - Exception: the top digit has max 9 regardless of index.
  - MAXVAL = every digit at its max, e.g. 9959 for 4 digits.
- Load clamping: each loaded nibble above its max is clamped to that max (e.g. nibble 0xC → 9 on an even digit, 7 → 5 on an odd digit).
- Input priority in the same cycle: clear > load > start_stop.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- clear: any state → IDLE. Digits = 0, tick_cnt = 0.
- load: accepted in IDLE, PAUSE and EXPIRED. In PAUSE or EXPIRED it moves the state to IDLE; tick_cnt = 0. Ignored in RUN.
- start_stop in IDLE:
  - Latches count_up into the mode register and goes to RUN with tick_cnt = 0.
  - Ignored if mode = down and digits = 0.
  - Ignored if mode = up and digits = MAXVAL.
- count_up is sampled only on the IDLE→RUN edge. Changes during RUN or PAUSE have no effect.
- start_stop in RUN → PAUSE. tick_cnt holds its value; no step is lost or duplicated.
- start_stop in PAUSE → RUN. tick_cnt resumes from its held value.
- start_stop in EXPIRED → IDLE (acknowledge). Digits are unchanged.
- Stepping in RUN:
  - tick_cnt increments each clock.
  - When tick_cnt = TICK_DIV-1, tick_cnt wraps to 0 and the digits step on that edge.
  - The first step is therefore visible exactly TICK_DIV cycles after the start edge.
- Down step: BCD decrement with borrow. A digit at 0 wraps to its max and borrows from the next digit.
  - If the step result is all zero, the state goes to EXPIRED on the same edge.
- Up step: BCD increment with carry. A digit at its max wraps to 0 and carries to the next digit.
  - If the result equals MAXVAL, the state goes to EXPIRED on the same edge. The count saturates; it never wraps to 0.
- EXPIRED flashing:
  - flash = 1 on the first cycle in EXPIRED.
  - flash toggles every FLASH_DIV cycles; flash_cnt restarts from 0 on entry.
  - flash = 0 in every other state.
- running and expired are registered state decodes, valid in the same cycle the state is entered.
- Reset asserted mid-RUN: immediate return to reset values. No partial step.

Test Plan (NUM_DIGITS = 4, TICK_DIV = 4, FLASH_DIV = 3):
- Load 0x0102, down mode, start → digits 0101 four cycles after start, then 0100, then 0059 (borrow, tens clamp at 5); running = 1 throughout.
- Load 0x0001, down, start → after 4 cycles digits = 0000, expired = 1, flash reads 1,1,1,0,0,0,1…; start_stop → IDLE with flash = 0 and digits = 0000.
- Load 0x9958, up, start → 9959 after 4 cycles, then expired = 1 and digits held at 9959; a further start_stop gives IDLE, and a second start_stop from IDLE is ignored (at MAXVAL).
- Down from 0x0010: start, pause after 2 cycles, hold paused 10 cycles, resume → first step to 0009 occurs 2 cycles after resume; count_up toggled while paused has no effect.
- Load 0xFF7C → digits 9959 (clamped); load during RUN is ignored; clear, load and start_stop in the same cycle → IDLE with digits 0000.
- Assert reset mid-RUN while tick_cnt = 3 → all outputs 0 immediately; after release, start_stop from zero in down mode is ignored.
